// File: rtl/video_meas_pkg.sv
// Shared types, default widths and saturating-increment helper for the video timing meter.
package video_meas_pkg;

  typedef enum logic [1:0] {
    NOSIG,
    ACQ,
    LOCKED
  } meter_state_t;

  localparam int DEF_HW           = 10;
  localparam int DEF_VW           = 10;
  localparam int DEF_LOCK_FRAMES  = 2;
  localparam int DEF_TIMEOUT_CLKS = 100000;
  localparam int FRAME_CLK_W      = 32;

  // Increment that sticks at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Sync polarity normaliser with ce-qualified leading/trailing edge pulses (combinational, same ce cycle).
module sync_edge_det #(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic sync_raw,
  output logic active,
  output logic lead,
  output logic trail
);

  logic prev;

  assign active = ACT_LOW ? ~sync_raw : sync_raw;

  // History only advances on pixel enables so ce=0 toggling is invisible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else if (ce) begin
      prev <= active;
    end
  end

  assign lead  = ce & active & ~prev;
  assign trail = ce & ~active & prev;

endmodule

// File: rtl/video_timing_meter.sv
// Measures line/frame geometry from the pixel-enable/sync/blank stream, publishing once per vsync.
// MEAS_FRAME_CLK_EN builds the clk-per-frame counter; otherwise frame_clks is tied to 0.
module video_timing_meter
  import video_meas_pkg::*;
#(
  parameter int HW           = DEF_HW,
  parameter int VW           = DEF_VW,
  parameter int SYNC_ACT_LOW = 1,
  parameter int LOCK_FRAMES  = DEF_LOCK_FRAMES,
  parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ce_pix,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic                   hblank,
  input  logic                   vblank,
  output logic [HW-1:0]          h_total,
  output logic [HW-1:0]          h_active,
  output logic [HW-1:0]          h_sync,
  output logic [VW-1:0]          v_total,
  output logic [VW-1:0]          v_active,
  output logic [VW-1:0]          v_sync,
  output logic [FRAME_CLK_W-1:0] frame_clks,
  output logic                   meas_stb,
  output logic                   locked,
  output logic                   no_signal
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int MW = $clog2(LOCK_FRAMES + 1);

  function automatic logic [HW-1:0] h_inc(input logic [HW-1:0] v);
    return HW'(sat_inc(32'(v), HW));
  endfunction

  function automatic logic [VW-1:0] v_inc(input logic [VW-1:0] v);
    return VW'(sat_inc(32'(v), VW));
  endfunction

  logic hs_act, h_lead, h_trail;
  logic vs_act, v_lead, v_trail;

  sync_edge_det #(.ACT_LOW(SYNC_ACT_LOW != 0)) u_hs_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce_pix),
    .sync_raw (hsync),
    .active   (hs_act),
    .lead     (h_lead),
    .trail    (h_trail)
  );

  sync_edge_det #(.ACT_LOW(SYNC_ACT_LOW != 0)) u_vs_det (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce_pix),
    .sync_raw (vsync),
    .active   (vs_act),
    .lead     (v_lead),
    .trail    (v_trail)
  );

  logic [HW-1:0] hcnt, hact, hsw;
  logic [HW-1:0] shadow_htot, shadow_hact, shadow_hsw;
  logic [VW-1:0] vcnt, vact, vsw, shadow_vsw;
  logic [HW-1:0] htot_now, hact_now;
  logic [VW-1:0] vtot_now, vact_now;
  logic [TW-1:0] tcnt;
  logic [MW-1:0] match, match_nx;
  meter_state_t  state, state_nx;
  logic          publish, same, expire;

  // The leading-edge pixel is pixel 1 of the new line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt        <= '0;
      hact        <= '0;
      hsw         <= '0;
      shadow_htot <= '0;
      shadow_hact <= '0;
      shadow_hsw  <= '0;
    end else if (ce_pix) begin
      if (h_lead) begin
        shadow_htot <= hcnt;
        hcnt        <= HW'(1);
        shadow_hact <= hact;
        hact        <= hblank ? '0 : HW'(1);
        hsw         <= HW'(1);
      end else begin
        hcnt <= h_inc(hcnt);
        if (!hblank) hact <= h_inc(hact);
        if (hs_act)  hsw  <= h_inc(hsw);
      end
      if (h_trail) shadow_hsw <= hsw;
    end
  end

  // A line edge coinciding with the vsync edge belongs to the frame that is ending.
  assign htot_now = h_lead ? hcnt : shadow_htot;
  assign hact_now = h_lead ? hact : shadow_hact;
  assign vtot_now = h_lead ? v_inc(vcnt) : vcnt;
  assign vact_now = (h_lead && !vblank) ? v_inc(vact) : vact;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcnt       <= '0;
      vact       <= '0;
      vsw        <= '0;
      shadow_vsw <= '0;
    end else begin
      if (v_lead) begin
        vcnt <= '0;
        vact <= '0;
        vsw  <= h_lead ? VW'(1) : '0;
      end else if (h_lead) begin
        vcnt <= v_inc(vcnt);
        if (!vblank) vact <= v_inc(vact);
        if (vs_act)  vsw  <= v_inc(vsw);
      end
      if (v_trail) shadow_vsw <= vsw;
    end
  end

  assign publish = v_lead && (state != NOSIG);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_total  <= '0;
      h_active <= '0;
      h_sync   <= '0;
      v_total  <= '0;
      v_active <= '0;
      v_sync   <= '0;
      meas_stb <= 1'b0;
    end else begin
      meas_stb <= publish;
      if (publish) begin
        h_total  <= htot_now;
        h_active <= hact_now;
        h_sync   <= shadow_hsw;
        v_total  <= vtot_now;
        v_active <= vact_now;
        v_sync   <= shadow_vsw;
      end
    end
  end

`ifdef MEAS_FRAME_CLK_EN
  logic [FRAME_CLK_W-1:0] fcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt       <= '0;
      frame_clks <= '0;
    end else begin
      if (v_lead) fcnt <= FRAME_CLK_W'(1);
      else        fcnt <= sat_inc(fcnt, FRAME_CLK_W);
      if (publish) frame_clks <= fcnt;
    end
  end
`else
  assign frame_clks = '0;
`endif

  // Counts raw clk since the last hsync leading edge; parks at the limit while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (h_lead) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CLKS)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign expire = !h_lead && (tcnt >= TW'(TIMEOUT_CLKS - 1));
  assign same   = (htot_now == h_total) && (vtot_now == v_total);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= NOSIG;
      match <= '0;
    end else begin
      state <= state_nx;
      match <= match_nx;
    end
  end

  always_comb begin
    state_nx = state;
    match_nx = match;
    case (state)
      NOSIG: begin
        if (h_lead) begin
          state_nx = ACQ;
          match_nx = '0;
        end
      end
      ACQ: begin
        if (publish) begin
          if (same) begin
            match_nx = match + MW'(1);
            if (match_nx == MW'(LOCK_FRAMES)) state_nx = LOCKED;
          end else begin
            match_nx = '0;
          end
        end
      end
      LOCKED: begin
        if (publish && !same) begin
          state_nx = ACQ;
          match_nx = '0;
        end
      end
      default: begin
        state_nx = NOSIG;
        match_nx = '0;
      end
    endcase
    if (expire) begin
      state_nx = NOSIG;
      match_nx = '0;
    end
  end

  assign locked    = (state == LOCKED);
  assign no_signal = (state == NOSIG);

endmodule

// File: tb/tb_video_timing_meter.sv
// Directed bench for video_timing_meter on a 48x20-line raster (32x14 active, hsync 4 px, vsync 3 lines, ce every 2 clk).
module tb_video_timing_meter;

  localparam int TO = 5000;
`ifdef MEAS_FRAME_CLK_EN
  localparam int FC48 = 48 * 20 * 2;
  localparam int FC47 = 47 * 20 * 2;
`else
  localparam int FC48 = 0;
  localparam int FC47 = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, ce_pix, hsync, vsync, hblank, vblank;
  logic [9:0]  h_total, h_active, h_sync, v_total, v_active, v_sync;
  logic [31:0] frame_clks;
  logic        meas_stb, locked, no_signal;

  always #5 clk = ~clk;

  video_timing_meter #(
    .HW           (10),
    .VW           (10),
    .SYNC_ACT_LOW (1),
    .LOCK_FRAMES  (2),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce_pix     (ce_pix),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblank     (hblank),
    .vblank     (vblank),
    .h_total    (h_total),
    .h_active   (h_active),
    .h_sync     (h_sync),
    .v_total    (v_total),
    .v_active   (v_active),
    .v_sync     (v_sync),
    .frame_clks (frame_clks),
    .meas_stb   (meas_stb),
    .locked     (locked),
    .no_signal  (no_signal)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Snapshot of every publish, indexed from 1.
  int pub_n = 0;
  int pub_ht [0:63];
  int pub_vt [0:63];
  int pub_lk [0:63];
  int l_ha, l_hs, l_va, l_vs, l_fc;

  always @(negedge clk) begin
    if (meas_stb === 1'b1 && pub_n < 63) begin
      pub_n = pub_n + 1;
      pub_ht[pub_n] = int'(h_total);
      pub_vt[pub_n] = int'(v_total);
      pub_lk[pub_n] = int'(locked);
      l_ha = int'(h_active);
      l_hs = int'(h_sync);
      l_va = int'(v_active);
      l_vs = int'(v_sync);
      l_fc = int'(frame_clks);
    end
  end

  task automatic pix(input bit hs, input bit vs, input bit hb, input bit vb);
    hsync  = ~hs;
    vsync  = ~vs;
    hblank = hb;
    vblank = vb;
    ce_pix = 1'b1;
    @(posedge clk); #1;
    ce_pix = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic gen_line(input int len, input bit vs, input bit vb);
    for (int p = 0; p < len; p++) pix(p < 4, vs, (p < 8) || (p >= 40), vb);
  endtask

  task automatic gen_lines(input int first, input int last, input int len);
    for (int l = first; l <= last; l++) gen_line(len, l < 3, (l < 4) || (l >= 18));
  endtask

  task automatic gen_frame(input int len);
    gen_lines(0, 19, len);
  endtask

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    hblank  = 1'b1;
    vblank  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_h_total", int'(h_total), 0);
    check("rst_v_total", int'(v_total), 0);
    check("rst_frame_clks", int'(frame_clks), 0);
    check("rst_meas_stb", int'(meas_stb), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_no_signal", int'(no_signal), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Nominal raster from the start of a frame: first publish is a full frame.
    repeat (4) gen_frame(48);
    check("t1_pub_count", pub_n, 3);
    check("t1_h_total", pub_ht[3], 48);
    check("t1_h_active", l_ha, 32);
    check("t1_h_sync", l_hs, 4);
    check("t1_v_total", pub_vt[3], 20);
    check("t1_v_active", l_va, 14);
    check("t1_v_sync", l_vs, 3);
    check("t1_frame_clks", l_fc, FC48);
    check("t1_lock_pub1", pub_lk[1], 0);
    check("t1_lock_pub2", pub_lk[2], 0);
    check("t1_lock_pub3", pub_lk[3], 1);
    check("t1_no_signal", int'(no_signal), 0);

    // Line shortened by one pixel while locked.
    repeat (4) gen_frame(47);
    check("t2_pub_count", pub_n, 7);
    check("t2_h_total_pub4", pub_ht[4], 48);
    check("t2_lock_pub4", pub_lk[4], 1);
    check("t2_h_total_pub5", pub_ht[5], 47);
    check("t2_lock_pub5", pub_lk[5], 0);
    check("t2_lock_pub6", pub_lk[6], 0);
    check("t2_lock_pub7", pub_lk[7], 1);
    check("t2_frame_clks", l_fc, FC47);

    // One last hsync leading edge, then silence.
    hsync  = 1'b0;
    ce_pix = 1'b1;
    @(posedge clk); #1;
    ce_pix = 1'b0;
    hsync  = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      if (k == TO - 1) check("t3_no_signal_early", int'(no_signal), 0);
    end
    check("t3_no_signal", int'(no_signal), 1);
    check("t3_locked", int'(locked), 0);
    check("t3_h_total_hold", int'(h_total), 47);
    pix(0, 0, 1, 1);

    // Signal returns; reset asserted mid-frame.
    gen_frame(48);
    gen_lines(0, 9, 48);
    #3 reset_n = 1'b0;
    #2;
    check("t4_h_total", int'(h_total), 0);
    check("t4_v_total", int'(v_total), 0);
    check("t4_h_sync", int'(h_sync), 0);
    check("t4_frame_clks", int'(frame_clks), 0);
    check("t4_no_signal", int'(no_signal), 1);
    check("t4_locked", int'(locked), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    base = pub_n;
    gen_lines(10, 19, 48);
    repeat (4) gen_frame(48);
    check("t4_pub_count", pub_n - base, 4);
    check("t4_v_total_partial", pub_vt[base + 1], 11);
    check("t4_h_total_r1", pub_ht[base + 1], 48);
    check("t4_v_total_r2", pub_vt[base + 2], 20);
    check("t4_lock_r1", pub_lk[base + 1], 0);
    check("t4_lock_r2", pub_lk[base + 2], 0);
    check("t4_lock_r3", pub_lk[base + 3], 0);
    check("t4_lock_r4", pub_lk[base + 4], 1);

    // 2000-pixel last line saturates the horizontal measurement.
    base = pub_n;
    gen_lines(0, 18, 48);
    gen_line(2000, 1'b0, 1'b1);
    gen_line(48, 1'b1, 1'b1);
    check("t5_pub_count", pub_n - base, 2);
    check("t5_h_total_sat", pub_ht[base + 2], 1023);
    check("t5_v_total", pub_vt[base + 2], 20);
    check("t5_lock_drop", pub_lk[base + 2], 0);

    // Sync and blank toggling with no pixel enables must be ignored.
    base = pub_n;
    for (int k = 0; k < 40; k++) begin
      hsync  = ~hsync;
      hblank = ~hblank;
      if (k % 3 == 0) vsync = ~vsync;
      if (k % 5 == 0) vblank = ~vblank;
      @(posedge clk); #1;
    end
    check("t5_ce0_no_stb", pub_n - base, 0);
    check("t5_ce0_h_total", int'(h_total), 1023);
    check("t5_ce0_v_total", int'(v_total), 20);
    check("t5_ce0_h_active", int'(h_active), 32);
    check("t5_ce0_no_signal", int'(no_signal), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
